// File: rtl/ipad_filt.sv
// ipad_filt: multi-channel pad input synchroniser with consecutive-sample glitch filter
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   inpad      asynchronous pad levels, WIDTH bits
//   glitch_clr synchronous clear of all glitch bits
//   inpad_q    filtered, synchronised level
//   rise/fall  one-cycle pulses coincident with the first cycle of a new inpad_q value
//   glitch     sticky flag: a mismatch run ended before it was accepted
module ipad_filt #(
    parameter int WIDTH = 1,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] INVERT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inpad,
    input  logic             glitch_clr,
    output logic [WIDTH-1:0] inpad_q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] glitch
);
    localparam int CW = FILTER_CYCLES > 1 ? $clog2(FILTER_CYCLES) : 1;

    logic [WIDTH-1:0] sync [SYNC_STAGES];
    logic [CW-1:0]    cnt [WIDTH];
    logic [CW-1:0]    cnt_nxt [WIDTH];
    logic [WIDTH-1:0] s, mis, done, nq, gset;

    assign s = sync[SYNC_STAGES-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        assign mis[i]     = s[i] != inpad_q[i];
        assign done[i]    = cnt[i] == CW'(FILTER_CYCLES - 1);
        assign nq[i]      = (mis[i] && done[i]) ? s[i] : inpad_q[i];
        // a run that falls back to the current level before completing counts as a glitch
        assign gset[i]    = !mis[i] && (cnt[i] != '0);
        assign cnt_nxt[i] = (mis[i] && !done[i]) ? cnt[i] + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync[k] <= RESET_VAL;
            for (int k = 0; k < WIDTH; k++) cnt[k] <= '0;
            inpad_q <= RESET_VAL;
            rise    <= '0;
            fall    <= '0;
            glitch  <= '0;
        end else begin
            sync[0] <= inpad ^ INVERT;
            for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
            cnt     <= cnt_nxt;
            inpad_q <= nq;
            rise    <= ~inpad_q & nq;
            fall    <= inpad_q & ~nq;
            // set takes priority over a same-edge clear
            glitch  <= (glitch & ~{WIDTH{glitch_clr}}) | gset;
        end
    end
endmodule

// File: tb/tb_ipad_filt.sv
// tb_ipad_filt: directed self-checking bench for ipad_filt
module tb_ipad_filt;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       glitch_clr = 1'b0;
    logic [3:0] inpad = 4'b0000;
    logic [3:0] inpad_q, rise, fall, glitch;
    int vecs = 0;
    int errs = 0;

    ipad_filt #(
        .WIDTH(4),
        .SYNC_STAGES(2),
        .FILTER_CYCLES(4),
        .RESET_VAL(4'b1010),
        .INVERT(4'b0100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .inpad(inpad),
        .glitch_clr(glitch_clr),
        .inpad_q(inpad_q),
        .rise(rise),
        .fall(fall),
        .glitch(glitch)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] q, input logic [3:0] r,
                           input logic [3:0] f, input logic [3:0] g);
        chk({tag, ".q"}, inpad_q, q);
        chk({tag, ".rise"}, rise, r);
        chk({tag, ".fall"}, fall, f);
        chk({tag, ".glitch"}, glitch, g);
    endtask

    initial begin
        // reset held two cycles
        tick(2);
        chk_all("reset", 4'b1010, 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b0;
        // after release the sync chain settles onto the idle pads (ch2 inverted -> 1)
        tick(1);
        chk_all("release_e1", 4'b1010, 4'b0000, 4'b0000, 4'b0000);
        tick(4);
        chk_all("settle_e5", 4'b1010, 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        chk_all("settle_e6", 4'b0100, 4'b0100, 4'b1010, 4'b0000);
        tick(1);
        chk_all("settle_e7", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        // clean rise on ch0
        inpad = 4'b0001;
        tick(5);
        chk_all("rise0_e5", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        chk_all("rise0_e6", 4'b0101, 4'b0001, 4'b0000, 4'b0000);
        tick(1);
        chk_all("rise0_e7", 4'b0101, 4'b0000, 4'b0000, 4'b0000);
        // 3-cycle pulse on ch1 is rejected
        inpad = 4'b0011;
        tick(3);
        inpad = 4'b0001;
        tick(2);
        chk_all("glitch1_e5", 4'b0101, 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        chk_all("glitch1_e6", 4'b0101, 4'b0000, 4'b0000, 4'b0010);
        tick(2);
        chk("glitch1_hold", glitch, 4'b0010);
        glitch_clr = 1'b1;
        tick(1);
        glitch_clr = 1'b0;
        chk("glitch1_clr", glitch, 4'b0000);
        // inverted ch2: pad 0->1 gives a falling output
        inpad = 4'b0101;
        tick(5);
        chk_all("fall2_e5", 4'b0101, 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        chk_all("fall2_e6", 4'b0001, 4'b0000, 4'b0100, 4'b0000);
        tick(1);
        chk_all("fall2_e7", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        // bring ch0 low, then reset in the middle of a new 0->1 run
        inpad = 4'b0100;
        tick(8);
        chk_all("pre_mid", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        inpad = 4'b0101;
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_all("mid_rst", 4'b1010, 4'b0000, 4'b0000, 4'b0000);
        tick(5);
        chk_all("mid_rel_e5", 4'b1010, 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        chk_all("mid_rel_e6", 4'b0001, 4'b0001, 4'b1010, 4'b0000);
        tick(1);
        chk_all("mid_rel_e7", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        // glitch set and glitch_clr on the same edge: set wins
        inpad = 4'b0111;
        tick(3);
        inpad = 4'b0101;
        tick(2);
        chk("same_edge_pre", glitch, 4'b0000);
        glitch_clr = 1'b1;
        tick(1);
        glitch_clr = 1'b0;
        chk_all("same_edge", 4'b0001, 4'b0000, 4'b0000, 4'b0010);
        glitch_clr = 1'b1;
        tick(1);
        glitch_clr = 1'b0;
        chk("same_edge_clr", glitch, 4'b0000);
        // ch0 falls and ch3 rises in the same cycle
        inpad = 4'b1100;
        tick(5);
        chk_all("dual_e5", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        chk_all("dual_e6", 4'b1000, 4'b1000, 4'b0001, 4'b0000);
        tick(1);
        chk_all("dual_e7", 4'b1000, 4'b0000, 4'b0000, 4'b0000);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/ipad_filt.md
# ipad_filt

Parametrised, multi-channel successor to the plain input-pad primitive: `WIDTH` pad inputs, each passed through a configurable synchroniser chain and a per-channel consecutive-sample glitch filter. Produces the filtered level plus one-cycle rise/fall pulses and a sticky glitch flag per channel. Sits directly behind the pad ring, feeding clean single-clock-domain signals into fabric logic; carries `CLASS="input"` semantics for the pad-facing port.

## Interface
Parameters:
- `WIDTH`, 1: number of independent pad channels (≥1).
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).
- `FILTER_CYCLES`, 4: consecutive mismatching synchronised samples required before the output changes (≥1; 1 = no filtering beyond sync).
- `RESET_VAL`, 0: `WIDTH`-bit value loaded into all synchroniser stages and `inpad_q` on reset.
- `INVERT`, 0: `WIDTH`-bit mask; bit i set inverts channel i at the pad, before the first sync stage.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `inpad`  input  WIDTH  asynchronous pad levels.
- `glitch_clr`  input  1  synchronous clear of all `glitch` bits.
- `inpad_q`  output  WIDTH  filtered, synchronised level.
- `rise`  output  WIDTH  one-cycle pulse after `inpad_q[i]` goes 0→1.
- `fall`  output  WIDTH  one-cycle pulse after `inpad_q[i]` goes 1→0.
- `glitch`  output  WIDTH  sticky: a mismatch run on channel i ended before reaching `FILTER_CYCLES`.

## Operation
- Channels fully independent; no cross-channel logic.
- Sync chain: stage 0 samples `inpad[i] ^ INVERT[i]`; stage k samples stage k-1. `s[i]` = last stage.
- Filter per channel: counter `cnt` width `$clog2(FILTER_CYCLES)` (min 1 bit). Each edge:
  - `s != inpad_q` and `cnt == FILTER_CYCLES-1`: `inpad_q <= s`, `cnt <= 0`.
  - `s != inpad_q` and `cnt < FILTER_CYCLES-1`: `cnt <= cnt+1`.
  - `s == inpad_q`: `cnt <= 0`; if `cnt != 0` beforehand, `glitch[i] <= 1`.
- `FILTER_CYCLES == 1`: `inpad_q` follows `s` with one edge delay; `cnt` unused, `glitch` never set.
- `rise[i] <= ~inpad_q[i] & next_inpad_q[i]`; `fall[i] <= inpad_q[i] & ~next_inpad_q[i]`; registered, high exactly one cycle, coincident with first cycle of new `inpad_q` value.
- `glitch`: set as above, held until `rst` or `glitch_clr`. Same-edge set and `glitch_clr`: set wins (bit reads 1).
- Reset (any time, including mid-run): next edge loads sync stages and `inpad_q` with `RESET_VAL`, `cnt` 0, `rise`/`fall`/`glitch` 0. No edge pulse is generated by the reset load itself.

## Timing
- Reset values: `inpad_q = RESET_VAL`, `rise = 0`, `fall = 0`, `glitch = 0`.
- Latency: pad change stable before edge 1 → `s` updates after edge `SYNC_STAGES` → `inpad_q`, `rise`/`fall` update after edge `SYNC_STAGES + FILTER_CYCLES` (defaults: edge 6).
- Minimum accepted pulse width at `s`: `FILTER_CYCLES` cycles; shorter runs are rejected and set `glitch`.
- Opposite toggle during a run: counter restarts from 0; no partial credit.
- Max edge rate out: one transition per `FILTER_CYCLES` cycles per channel.
- All outputs registered; no combinational path from `inpad` or `glitch_clr` to any output.

## Test plan
- Reset: `WIDTH=4`, `RESET_VAL=4'b1010`, hold `rst` 2 cycles → `inpad_q=4'b1010`, `rise=fall=glitch=0`, no pulses on release.
- Clean rise, defaults: `inpad[0]` 0→1 before edge 1 → `inpad_q[0]=1` and `rise[0]=1` after edge 6, `rise[0]=0` after edge 7; `fall` stays 0.
- Glitch reject: 3-cycle high pulse on `inpad[1]` (`FILTER_CYCLES=4`) → `inpad_q[1]` stays 0, `glitch[1]=1` after run ends, holds until `glitch_clr` pulse → 0 next edge.
- Invert + fall: `INVERT=4'b0100`, `inpad[2]` held 0 then 0→1 → `inpad_q[2]` 1→0 at latency 6, `fall[2]` one-cycle pulse.
- Reset mid-run: start 0→1 on channel 0, assert `rst` after edge 4 → `cnt` cleared, `inpad_q[0]=RESET_VAL[0]`, no `rise`; after release, full 6-edge latency repeats.
- Simultaneous: `glitch` set and `glitch_clr` same edge → `glitch=1`; independent edges on channels 0 and 3 same cycle → both pulse same cycle.
